mod5_word_serializer: RTL and testbench

//  Upstream feeder for the serial mod-5 divisibility detector. Accepts WIDTH-bit

---
 rtl/mod5_word_serializer.sv | 111 +++++++++++
 tb/tb_mod5_word_serializer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod5_word_serializer.sv
// Word-to-bit serializer feeding the serial mod-5 divisibility detector.
// Buffers one word, clears the detector before each word, flags the verdict.
module mod5_word_serializer #(
  parameter int WIDTH      = 8,
  parameter int CLR_CYCLES = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             ser_clr_n,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             res_sample,
  output logic             busy
);

  localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam int BW = $clog2(WIDTH);
  localparam logic [CW-1:0] CLR_INIT = CW'(CLR_CYCLES - 1);
  localparam logic [BW-1:0] BIT_INIT = BW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] hold, shift_reg;
  logic             hold_full;
  logic [CW-1:0]    clr_cnt;
  logic [BW-1:0]    bit_cnt;
  logic             load, accept, clr_done, bit_done;

  assign accept   = in_valid && !hold_full;
  assign clr_done = (clr_cnt == '0);
  assign bit_done = (bit_cnt == '0);

  assign in_ready  = !hold_full;
  assign ser_valid = (state == SHIFT);
  assign ser_clr_n = (state == SHIFT);
  assign ser_bit   = (state == SHIFT) && shift_reg[WIDTH-1];
  assign ser_last  = (state == SHIFT) && bit_done;
  assign busy      = (state != IDLE) || hold_full;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  // load moves the held word into the shifter and empties the hold
  always_comb begin
    state_n = state;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (hold_full) begin
          state_n = CLEAR;
          load    = 1'b1;
        end
      end
      CLEAR: begin
        if (clr_done) state_n = SHIFT;
      end
      SHIFT: begin
        if (bit_done) begin
          if (hold_full) begin
            state_n = CLEAR;
            load    = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (accept) begin
      hold      <= in_data;
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shift_reg  <= '0;
      clr_cnt    <= '0;
      bit_cnt    <= '0;
      res_sample <= 1'b0;
    end else begin
      res_sample <= ser_valid && ser_last;
      if (load) begin
        shift_reg <= hold;
        clr_cnt   <= CLR_INIT;
      end else if (state == SHIFT) begin
        shift_reg <= shift_reg << 1;
        bit_cnt   <= bit_cnt - BW'(1);
      end else if (state == CLEAR) begin
        if (clr_done) bit_cnt <= BIT_INIT;
        else          clr_cnt <= clr_cnt - CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mod5_word_serializer.sv
// Bench for mod5_word_serializer with behavioural mod-5 detectors.
// Scoreboard checks bit streams and verdicts against word % 5.
module tb_mod5_word_serializer;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid, in_ready, ser_clr_n, ser_bit;
  logic       ser_valid, ser_last, res_sample, busy;
  logic [7:0] in_data;

  logic       b_valid, b_ready, b_clr_n, b_bit;
  logic       b_sv, b_last, b_res, b_busy;
  logic [7:0] b_data;

  mod5_word_serializer #(.WIDTH(8), .CLR_CYCLES(1)) dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .ser_clr_n(ser_clr_n), .ser_bit(ser_bit), .ser_valid(ser_valid),
    .ser_last(ser_last), .res_sample(res_sample), .busy(busy)
  );

  mod5_word_serializer #(.WIDTH(8), .CLR_CYCLES(3)) dut3 (
    .clk(clk), .resetn(resetn),
    .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
    .ser_clr_n(b_clr_n), .ser_bit(b_bit), .ser_valid(b_sv),
    .ser_last(b_last), .res_sample(b_res), .busy(b_busy)
  );

  // serial detectors: residue of the bits seen since the last clear
  logic [2:0] ra = 3'd0, rb = 3'd0;
  logic       dout_a, dout_b;
  always @(posedge clk) begin
    ra <= !ser_clr_n ? 3'd0 : 3'((int'(ra) * 2 + int'(ser_bit)) % 5);
    rb <= !b_clr_n ? 3'd0 : 3'((int'(rb) * 2 + int'(b_bit)) % 5);
  end
  assign dout_a = (ra == 3'd0);
  assign dout_b = (rb == 3'd0);

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  logic [7:0] acc_q[$];
  logic [7:0] vq[$];
  int         log_cyc[$];
  logic       log_d[$];
  logic [7:0] sh = 8'd0;
  int         nb = 0;

  always @(negedge clk) begin
    logic [7:0] w;
    if (!resetn) begin
      nb = 0;
    end else begin
      if (res_sample) begin
        if (vq.size() == 0) chk("spur_res", 1, 0);
        else begin
          w = vq.pop_front();
          chk("verdict", dout_a, (int'(w) % 5) == 0);
          log_cyc.push_back(cyc);
          log_d.push_back(dout_a);
        end
      end
      if (ser_valid) begin
        sh = {sh[6:0], ser_bit};
        nb++;
        if (ser_last) begin
          chk("nbits", nb, 8);
          if (acc_q.size() == 0) chk("spur_word", 1, 0);
          else begin
            w = acc_q.pop_front();
            chk("bits", sh, w);
            vq.push_back(w);
          end
          nb = 0;
        end
      end
    end
  end

  int   b_res_cyc[$];
  logic b_res_d[$];
  int   gaps[$];
  int   gap = 0;
  bit   counting = 1'b0;
  always @(negedge clk) begin
    if (resetn) begin
      if (b_res) begin
        b_res_cyc.push_back(cyc);
        b_res_d.push_back(dout_b);
      end
      if (b_sv) begin
        if (counting) begin
          gaps.push_back(gap);
          counting = 1'b0;
        end
        if (b_last) begin
          counting = 1'b1;
          gap = 0;
        end
      end else if (counting && !b_clr_n) begin
        gap++;
      end
    end
  end

  // called at a negedge; returns at the negedge after the transfer edge
  task automatic send(input logic [7:0] w);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("send_to", in_ready, 1);
    end else begin
      acc_q.push_back(w);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic wait_res(output int n, output logic d);
    n = 0;
    d = 1'b0;
    repeat (60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (res_sample) begin
        d = dout_a;
        return;
      end
    end
    chk("res_to", 0, 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((acc_q.size() + vq.size()) != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("drain", acc_q.size() + vq.size(), 0);
  endtask

  initial begin
    int n, k, t, t0, cnt, base;
    logic d;
    in_valid = 1'b0;
    in_data  = 8'd0;
    b_valid  = 1'b0;
    b_data   = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_clr_n", ser_clr_n, 0);
    chk("rst_valid", ser_valid, 0);
    chk("rst_last", ser_last, 0);
    chk("rst_bit", ser_bit, 0);
    chk("rst_res", res_sample, 0);
    chk("rst_busy", busy, 0);
    resetn = 1'b1;
    @(negedge clk);

    send(8'h0A);
    wait_res(n, d);
    chk("t1_lat", n, 10);
    chk("t1_dout", d, 1);
    drain();

    send(8'h07);
    wait_res(n, d);
    chk("t2_07", d, 0);
    send(8'hFF);
    wait_res(n, d);
    chk("t2_ff", d, 1);
    drain();

    send(8'h05);
    chk("t3_ready0", in_ready, 0);
    chk("t3_busy", busy, 1);
    send(8'h0B);
    send(8'h0F);
    drain();
    k = log_d.size();
    if (k >= 3) begin
      chk("t3_v0", log_d[k-3], 1);
      chk("t3_v1", log_d[k-2], 0);
      chk("t3_v2", log_d[k-1], 1);
      chk("t3_sp0", log_cyc[k-2] - log_cyc[k-3], 9);
      chk("t3_sp1", log_cyc[k-1] - log_cyc[k-2], 9);
    end else begin
      chk("t3_cnt", k, 3);
    end

    send(8'hAA);
    t = 0;
    while (!ser_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("t4_start", ser_valid, 1);
    repeat (4) @(negedge clk);
    chk("t4_bit4", ser_bit, 1);
    #2 resetn = 1'b0;
    #1;
    chk("t4_clr_n", ser_clr_n, 0);
    chk("t4_valid", ser_valid, 0);
    chk("t4_last", ser_last, 0);
    chk("t4_bit", ser_bit, 0);
    chk("t4_res", res_sample, 0);
    chk("t4_busy", busy, 0);
    chk("t4_ready", in_ready, 1);
    acc_q.delete();
    vq.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (res_sample) cnt++;
    end
    chk("t4_nores", cnt, 0);
    send(8'h14);
    wait_res(n, d);
    chk("t4_14", d, 1);
    drain();

    chk("t5_ready", b_ready, 1);
    b_valid = 1'b1;
    b_data  = 8'h19;
    @(posedge clk);
    @(negedge clk);
    t0 = cyc;
    b_data = 8'h33;
    t = 0;
    while (!b_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("t5_acc2", b_ready, 1);
    @(posedge clk);
    @(negedge clk);
    b_valid = 1'b0;
    t = 0;
    while (b_res_d.size() < 2 && t < 80) begin
      @(negedge clk);
      t++;
    end
    if (b_res_d.size() >= 2 && gaps.size() >= 1) begin
      chk("t5_lat", b_res_cyc[0] - t0, 12);
      chk("t5_gap", gaps[0], 3);
      chk("t5_sp", b_res_cyc[1] - b_res_cyc[0], 11);
      chk("t5_v19", b_res_d[0], 1);
      chk("t5_v33", b_res_d[1], 0);
    end else begin
      chk("t5_cnt", b_res_d.size(), 2);
    end

    base = log_d.size();
    for (int i = 0; i < 3000; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(8'($urandom));
    end
    drain();
    chk("t6_count", log_d.size() - base, 3000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
